// File: rtl/frequency_generator.sv
// frequency_generator: emits N (BCD-loaded, 0..99) evenly spaced 1-clk pulses per window of W clocks.
// Defining FREQ_GEN_ONESHOT_EN adds a `oneshot` input that stops the generator after the current window.
module frequency_generator #(
    parameter int BITS           = 12,
    parameter int DEFAULT_PERIOD = 1200,
    parameter int MAX_COUNT      = 99
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [3:0]      ten_count,
    input  logic [3:0]      unit_count,
    input  logic            load,
    input  logic [BITS-1:0] period,
    input  logic            period_load,
`ifdef FREQ_GEN_ONESHOT_EN
    input  logic            oneshot,
`endif
    output logic            signal,
    output logic            busy,
    output logic            window_done
);

    localparam int SW    = BITS + 1;
    localparam int W_MIN = 2 * MAX_COUNT;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t          r_state;
    logic [6:0]      r_n;
    logic [BITS-1:0] r_w;
    logic [6:0]      r_pend_n;
    logic            r_pend_n_v;
    logic [BITS-1:0] r_pend_w;
    logic            r_pend_w_v;
    logic [BITS-1:0] r_acc;
    logic [BITS-1:0] r_cnt;
    logic            r_signal;
    logic            r_busy;
    logic            r_window_done;

    logic [3:0]      w_tens;
    logic [3:0]      w_units;
    logic [6:0]      w_new_n;
    logic [BITS-1:0] w_new_w;
    logic [6:0]      w_eff_n;
    logic            w_eff_n_v;
    logic [BITS-1:0] w_eff_w;
    logic            w_eff_w_v;
    logic [SW-1:0]   w_sum;
    logic            w_hit;
    logic            w_last;
    logic            w_oneshot;

`ifdef FREQ_GEN_ONESHOT_EN
    assign w_oneshot = oneshot;
`else
    assign w_oneshot = 1'b0;
`endif

    assign w_tens  = (ten_count  > 4'd9) ? 4'd9 : ten_count;
    assign w_units = (unit_count > 4'd9) ? 4'd9 : unit_count;
    assign w_new_n = 7'(w_tens) * 7'd10 + 7'(w_units);
    assign w_new_w = (period < BITS'(W_MIN)) ? BITS'(W_MIN) : period;

    // A strobe in the applying cycle itself wins over the older pending value.
    assign w_eff_n   = load ? w_new_n : r_pend_n;
    assign w_eff_n_v = load | r_pend_n_v;
    assign w_eff_w   = period_load ? w_new_w : r_pend_w;
    assign w_eff_w_v = period_load | r_pend_w_v;

    assign w_sum  = {1'b0, r_acc} + SW'(r_n);
    assign w_hit  = (w_sum >= {1'b0, r_w});
    assign w_last = (r_cnt == (r_w - 1'b1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_n           <= '0;
            r_w           <= BITS'(DEFAULT_PERIOD);
            r_pend_n      <= '0;
            r_pend_n_v    <= 1'b0;
            r_pend_w      <= '0;
            r_pend_w_v    <= 1'b0;
            r_acc         <= '0;
            r_cnt         <= '0;
            r_signal      <= 1'b0;
            r_busy        <= 1'b0;
            r_window_done <= 1'b0;
        end else begin
            r_signal      <= 1'b0;
            r_window_done <= 1'b0;
            if (load) begin
                r_pend_n   <= w_new_n;
                r_pend_n_v <= 1'b1;
            end
            if (period_load) begin
                r_pend_w   <= w_new_w;
                r_pend_w_v <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    r_busy <= 1'b0;
                    if (period_load) begin
                        r_w        <= w_new_w;
                        r_pend_w_v <= 1'b0;
                    end
                    if (load) begin
                        r_state <= S_ARM;
                        r_busy  <= 1'b1;
                    end
                end
                S_ARM: begin
                    if (w_eff_n_v) r_n <= w_eff_n;
                    if (w_eff_w_v) r_w <= w_eff_w;
                    r_pend_n_v <= 1'b0;
                    r_pend_w_v <= 1'b0;
                    r_acc      <= '0;
                    r_cnt      <= '0;
                    r_state    <= S_RUN;
                    r_busy     <= 1'b1;
                end
                S_RUN: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_hit) begin
                        r_acc    <= BITS'(w_sum - {1'b0, r_w});
                        r_signal <= 1'b1;
                    end else begin
                        r_acc <= BITS'(w_sum);
                    end
                    if (w_last) begin
                        r_window_done <= 1'b1;
                        r_acc         <= '0;
                        r_cnt         <= '0;
                        if (w_oneshot) begin
                            // Pending values stay queued for the next ARM.
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            if (w_eff_n_v) r_n <= w_eff_n;
                            if (w_eff_w_v) r_w <= w_eff_w;
                            r_pend_n_v <= 1'b0;
                            r_pend_w_v <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign signal      = r_signal;
    assign busy        = r_busy;
    assign window_done = r_window_done;

endmodule

// File: tb/tb_frequency_generator.sv
// Self-checking bench for frequency_generator; expected pulse positions come from floor((k+1)*N/W) stepping.
// Builds with or without FREQ_GEN_ONESHOT_EN.
module tb_frequency_generator;

    localparam int BITS = 12;

    logic            clk;
    logic            reset;
    logic [3:0]      ten_count;
    logic [3:0]      unit_count;
    logic            load;
    logic [BITS-1:0] period;
    logic            period_load;
    logic            oneshot;
    logic            signal;
    logic            busy;
    logic            window_done;

    int n_cmp = 0;
    int n_bad = 0;
    logic prev_sig = 1'b0;

    typedef struct {
        int at;
        int tens;
        int units;
        int per;
        bit ld;
        bit pl;
    } strobe_t;
    strobe_t sched[$];

    frequency_generator #(.BITS(BITS), .DEFAULT_PERIOD(1200), .MAX_COUNT(99)) dut (
        .clk         (clk),
        .reset       (reset),
        .ten_count   (ten_count),
        .unit_count  (unit_count),
        .load        (load),
        .period      (period),
        .period_load (period_load),
`ifdef FREQ_GEN_ONESHOT_EN
        .oneshot     (oneshot),
`endif
        .signal      (signal),
        .busy        (busy),
        .window_done (window_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int model_n(input int t, input int u);
        return ((t > 9) ? 9 : t) * 10 + ((u > 9) ? 9 : u);
    endfunction

    function automatic int model_w(input int p);
        return (p < 198) ? 198 : p;
    endfunction

    // The k-th clock of a window carries a pulse when the ideal count k*N/W crosses an integer.
    function automatic bit model_pulse(input int k, input int n, input int w);
        return ((k + 1) * n) / w != (k * n) / w;
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        load = 1'b0;
        period_load = 1'b0;
        oneshot = 1'b0;
        ten_count = '0;
        unit_count = '0;
        period = '0;
        sched.delete();
        step();
        step();
        reset = 1'b1;
        step();
        prev_sig = 1'b0;
    endtask

    task automatic do_period(input int p);
        period = BITS'(p);
        period_load = 1'b1;
        step();
        period_load = 1'b0;
    endtask

    task automatic arm(input int tens, input int units, input bit do_per, input int per);
        ten_count = 4'(tens);
        unit_count = 4'(units);
        load = 1'b1;
        if (do_per) begin
            period = BITS'(per);
            period_load = 1'b1;
        end
        step();
        load = 1'b0;
        period_load = 1'b0;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL arm_busy: got %b expected 1", busy);
        end
        step();
    endtask

    task automatic check_window(input int n, input int w, input string name);
        int edges = 0;
        int pos_err = 0;
        int wd_err = 0;
        int busy_err = 0;
        int consec = 0;
        for (int k = 0; k < w; k++) begin
            step();
            if (signal !== model_pulse(k, n, w)) pos_err++;
            if (signal === 1'b1 && prev_sig === 1'b1) consec++;
            if (signal === 1'b1 && prev_sig !== 1'b1) edges++;
            if (window_done !== (k == w - 1)) wd_err++;
            if (busy !== 1'b1) busy_err++;
            prev_sig = signal;
            load = 1'b0;
            period_load = 1'b0;
            for (int i = sched.size() - 1; i >= 0; i--) begin
                if (sched[i].at == k) begin
                    if (sched[i].ld) begin
                        ten_count = 4'(sched[i].tens);
                        unit_count = 4'(sched[i].units);
                        load = 1'b1;
                    end
                    if (sched[i].pl) begin
                        period = BITS'(sched[i].per);
                        period_load = 1'b1;
                    end
                    sched.delete(i);
                end
            end
        end
        n_cmp++;
        if (edges != n) begin
            n_bad++;
            $display("FAIL %s edges: got %0d expected %0d (W=%0d)", name, edges, n, w);
        end
        n_cmp++;
        if (pos_err != 0) begin
            n_bad++;
            $display("FAIL %s pulse_positions: got %0d wrong cycles expected 0", name, pos_err);
        end
        n_cmp++;
        if (wd_err != 0) begin
            n_bad++;
            $display("FAIL %s window_done: got %0d wrong cycles expected 0", name, wd_err);
        end
        n_cmp++;
        if (consec != 0) begin
            n_bad++;
            $display("FAIL %s consecutive_high: got %0d expected 0", name, consec);
        end
        n_cmp++;
        if (busy_err != 0) begin
            n_bad++;
            $display("FAIL %s busy_in_run: got %0d low cycles expected 0", name, busy_err);
        end
    endtask

    task automatic test_reset();
        int idle_bad = 0;
        do_reset();
        n_cmp++;
        if (signal !== 1'b0) begin n_bad++; $display("FAIL reset_signal: got %b expected 0", signal); end
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_cmp++;
        if (window_done !== 1'b0) begin n_bad++; $display("FAIL reset_window_done: got %b expected 0", window_done); end
        for (int i = 0; i < 20; i++) begin
            step();
            if (signal !== 1'b0 || busy !== 1'b0 || window_done !== 1'b0) idle_bad++;
        end
        n_cmp++;
        if (idle_bad != 0) begin n_bad++; $display("FAIL idle_quiet: got %0d active cycles expected 0", idle_bad); end
    endtask

    task automatic test_zero_count();
        arm(0, 0, 1'b0, 0);
        check_window(0, 1200, "zero_w0");
        check_window(0, 1200, "zero_w1");
    endtask

    task automatic test_basic();
        do_reset();
        do_period(200);
        arm(4, 2, 1'b0, 0);
        for (int j = 0; j < 3; j++) check_window(42, 200, "basic_42_200");
    endtask

    task automatic test_max();
        do_reset();
        do_period(198);
        arm(9, 9, 1'b0, 0);
        check_window(99, 198, "max_w0");
        check_window(99, 198, "max_w1");
    endtask

    task automatic test_clamp();
        do_reset();
        do_period(50);
        arm(1, 0, 1'b0, 0);
        check_window(10, model_w(50), "clamp50_w0");
        check_window(10, model_w(50), "clamp50_w1");
        do_reset();
        arm(12, 15, 1'b1, 0);
        check_window(model_n(12, 15), model_w(0), "clamp0_sat");
    endtask

    task automatic test_midwindow_load();
        strobe_t s;
        do_reset();
        arm(1, 0, 1'b0, 0);
        s = '{at: 599, tens: 2, units: 5, per: 0, ld: 1'b1, pl: 1'b0};
        sched.push_back(s);
        check_window(10, 1200, "mid_old");
        check_window(25, 1200, "mid_new");
    endtask

    task automatic test_idle_random();
        for (int r = 0; r < 4; r++) begin
            int t, u, p;
            t = int'($urandom_range(0, 15));
            u = int'($urandom_range(0, 15));
            p = int'($urandom_range(0, 450));
            do_reset();
            arm(t, u, 1'b1, p);
            check_window(model_n(t, u), model_w(p), "idle_rand");
        end
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 3; r++) begin
            int cur_n, cur_w, t0, u0, p0;
            do_reset();
            t0 = int'($urandom_range(0, 15));
            u0 = int'($urandom_range(0, 15));
            p0 = int'($urandom_range(0, 500));
            arm(t0, u0, 1'b1, p0);
            cur_n = model_n(t0, u0);
            cur_w = model_w(p0);
            for (int j = 0; j < 6; j++) begin
                int nxt_n, nxt_w, mode, t1, u1, p1, t2, u2, a1, a2;
                strobe_t s;
                nxt_n = cur_n;
                nxt_w = cur_w;
                mode = int'($urandom_range(0, 5));
                t1 = int'($urandom_range(0, 15));
                u1 = int'($urandom_range(0, 15));
                p1 = int'($urandom_range(0, 500));
                t2 = int'($urandom_range(0, 15));
                u2 = int'($urandom_range(0, 15));
                a1 = int'($urandom_range(0, cur_w - 3));
                a2 = int'($urandom_range(a1 + 1, cur_w - 2));
                case (mode)
                    1: begin
                        s = '{at: a1, tens: t1, units: u1, per: 0, ld: 1'b1, pl: 1'b0};
                        sched.push_back(s);
                        nxt_n = model_n(t1, u1);
                    end
                    2: begin
                        s = '{at: a1, tens: 0, units: 0, per: p1, ld: 1'b0, pl: 1'b1};
                        sched.push_back(s);
                        nxt_w = model_w(p1);
                    end
                    3: begin
                        s = '{at: a1, tens: t1, units: u1, per: p1, ld: 1'b1, pl: 1'b1};
                        sched.push_back(s);
                        nxt_n = model_n(t1, u1);
                        nxt_w = model_w(p1);
                    end
                    4: begin
                        s = '{at: a1, tens: t1, units: u1, per: 0, ld: 1'b1, pl: 1'b0};
                        sched.push_back(s);
                        s = '{at: a2, tens: t2, units: u2, per: 0, ld: 1'b1, pl: 1'b0};
                        sched.push_back(s);
                        nxt_n = model_n(t2, u2);
                    end
                    5: begin
                        s = '{at: cur_w - 2, tens: t1, units: u1, per: p1, ld: 1'b1, pl: 1'b1};
                        sched.push_back(s);
                        nxt_n = model_n(t1, u1);
                        nxt_w = model_w(p1);
                    end
                    default: ;
                endcase
                check_window(cur_n, cur_w, "b2b");
                cur_n = nxt_n;
                cur_w = nxt_w;
            end
        end
    endtask

    task automatic test_reset_midrun();
        bit seen = 1'b0;
        int quiet_bad = 0;
        do_reset();
        arm(4, 0, 1'b0, 0);
        for (int k = 0; k < 300; k++) step();
        for (int i = 0; i < 100 && !seen; i++) begin
            step();
            if (signal === 1'b1) seen = 1'b1;
        end
        n_cmp++;
        if (!seen) begin n_bad++; $display("FAIL midrun_pulse_wait: got no pulse expected one within 100 clks"); end
        reset = 1'b0;
        #1;
        n_cmp++;
        if (signal !== 1'b0) begin n_bad++; $display("FAIL midrun_signal_drop: got %b expected 0", signal); end
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL midrun_busy_drop: got %b expected 0", busy); end
        step();
        reset = 1'b1;
        for (int i = 0; i < 30; i++) begin
            step();
            if (signal !== 1'b0 || busy !== 1'b0 || window_done !== 1'b0) quiet_bad++;
        end
        n_cmp++;
        if (quiet_bad != 0) begin n_bad++; $display("FAIL midrun_idle_after: got %0d active cycles expected 0", quiet_bad); end
        prev_sig = 1'b0;
        arm(0, 5, 1'b0, 0);
        check_window(5, 1200, "after_reset_default_w");
    endtask

`ifdef FREQ_GEN_ONESHOT_EN
    task automatic test_oneshot();
        strobe_t s;
        int quiet_bad = 0;
        do_reset();
        oneshot = 1'b1;
        arm(0, 7, 1'b1, 300);
        s = '{at: 10, tens: 0, units: 0, per: 250, ld: 1'b0, pl: 1'b1};
        sched.push_back(s);
        check_window(7, 300, "oneshot_win");
        for (int i = 0; i < 40; i++) begin
            step();
            if (signal !== 1'b0 || busy !== 1'b0 || window_done !== 1'b0) quiet_bad++;
        end
        n_cmp++;
        if (quiet_bad != 0) begin n_bad++; $display("FAIL oneshot_stop: got %0d active cycles expected 0", quiet_bad); end
        oneshot = 1'b0;
        prev_sig = 1'b0;
        arm(0, 4, 1'b0, 0);
        check_window(4, 250, "oneshot_rearm_pending_w");
    endtask
`endif

    initial begin
        reset = 1'b0;
        load = 1'b0;
        period_load = 1'b0;
        oneshot = 1'b0;
        ten_count = '0;
        unit_count = '0;
        period = '0;
        test_reset();
        test_zero_count();
        test_basic();
        test_max();
        test_clamp();
        test_midwindow_load();
        test_idle_random();
        test_back_to_back();
        test_reset_midrun();
`ifdef FREQ_GEN_ONESHOT_EN
        test_oneshot();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
